// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the pipelined immediate generator.
// slave = the generator, master = the block feeding and draining it.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_instr;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_imm;
  logic [2:0]       o_fmt;
  logic             o_illegal;
  logic [TAG_W-1:0] o_tag;

  modport slave (
    input  i_valid, i_instr, i_tag, i_ready,
    output o_ready, o_valid, o_imm, o_fmt, o_illegal, o_tag
  );

  modport master (
    output i_valid, i_instr, i_tag, i_ready,
    input  o_ready, o_valid, o_imm, o_fmt, o_illegal, o_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV64 immediate generator: combinational decode into a
// registered valid/ready output stage with a 2-entry skid.
module imm_gen_pipe_core #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic      i_clk,
  input  logic      i_reset,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;
  localparam logic [2:0] F_SH   = 3'd6;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_SKID  = 2'd2;

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_iop, is_sh, is_i;
  logic        is_s, is_b, is_u, is_j;
  logic [31:0] imm32;
  logic [2:0]  fmt;
  logic        ill;
  logic [XLEN-1:0] imm_ext;
  entry_t      new_e;

  assign ins = bus.i_instr;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];

  assign is_iop = (opc == 7'b0000011) || (opc == 7'b1100111)
               || (opc == 7'b0010011) || (opc == 7'b0011011);
  assign is_sh  = ((opc == 7'b0010011) || (opc == 7'b0011011))
               && ((f3 == 3'b001) || (f3 == 3'b101));
  assign is_i   = is_iop && !is_sh;
  assign is_s   = opc == 7'b0100011;
  assign is_b   = opc == 7'b1100011;
  assign is_u   = (opc == 7'b0110111) || (opc == 7'b0010111);
  assign is_j   = opc == 7'b1101111;

  // Shift amounts are built with a clear MSB so the common
  // sign-extension below zero-extends them.
  always_comb begin
    imm32 = '0;
    fmt   = F_NONE;
    ill   = 1'b0;
    unique case (1'b1)
      is_sh: begin
        fmt = F_SH;
        imm32 = opc[3] ? {27'b0, ins[24:20]}
                       : {26'b0, ins[25:20]};
      end
      is_i: begin
        fmt = F_I;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      is_s: begin
        fmt = F_S;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      is_b: begin
        fmt = F_B;
        imm32 = {{19{ins[31]}}, ins[31], ins[7],
                 ins[30:25], ins[11:8], 1'b0};
      end
      is_u: begin
        fmt = F_U;
        imm32 = {ins[31:12], 12'b0};
      end
      is_j: begin
        fmt = F_J;
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                 ins[20], ins[30:21], 1'b0};
      end
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    imm_ext[31:0] = imm32;
    for (int k = 32; k < XLEN; k++) imm_ext[k] = imm32[31];
  end

  assign new_e = '{imm: imm_ext, fmt: fmt,
                   ill: ill, tag: bus.i_tag};

  logic [1:0] state_q, state_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  logic       rdy, vld, accept, consume;

  assign rdy     = state_q != S_SKID;
  assign vld     = state_q != S_EMPTY;
  assign accept  = bus.i_valid && rdy;
  assign consume = vld && bus.i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = new_e;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (accept && consume) begin
          main_d = new_e;
        end else if (accept) begin
          skid_d  = new_e;
          state_d = S_SKID;
        end else if (consume) begin
          state_d = S_EMPTY;
        end
      end
      S_SKID: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = S_FULL;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.o_ready   = rdy;
  assign bus.o_valid   = vld;
  assign bus.o_imm     = main_q.imm;
  assign bus.o_fmt     = main_q.fmt;
  assign bus.o_illegal = main_q.ill;
  assign bus.o_tag     = main_q.tag;

endmodule

module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_fmt,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag
);

  imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  assign bus.i_valid = i_valid;
  assign bus.i_instr = i_instr;
  assign bus.i_tag   = i_tag;
  assign bus.i_ready = i_ready;
  assign o_ready     = bus.o_ready;
  assign o_valid     = bus.o_valid;
  assign o_imm       = bus.o_imm;
  assign o_fmt       = bus.o_fmt;
  assign o_illegal   = bus.o_illegal;
  assign o_tag       = bus.o_tag;

  imm_gen_pipe_core #(.XLEN(XLEN), .TAG_W(TAG_W)) u_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed vectors,
// backpressure, random streaming and async reset in SKID.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) bus ();

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_valid   (bus.i_valid),
    .o_ready   (bus.o_ready),
    .i_instr   (bus.i_instr),
    .i_tag     (bus.i_tag),
    .o_valid   (bus.o_valid),
    .i_ready   (bus.i_ready),
    .o_imm     (bus.o_imm),
    .o_fmt     (bus.o_fmt),
    .o_illegal (bus.o_illegal),
    .o_tag     (bus.o_tag)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   rdy_rand = 0;
  bit   rdy_fix  = 1;

  task automatic chk(string name, logic [63:0] got,
                     logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    bus.i_ready = rdy_rand ? 1'($urandom_range(0, 1))
                           : rdy_fix;
  end

  // Monitor: pops on each consume, checks stability on stalls.
  bit          hold = 0;
  logic [63:0] h_imm;
  logic [11:0] h_meta;
  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("stable_imm", bus.o_imm, h_imm);
        chk("stable_meta",
            64'({bus.o_fmt, bus.o_illegal, bus.o_tag}),
            64'(h_meta));
      end
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_out got_tag=%h exp=none",
                   bus.o_tag);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("imm", bus.o_imm, e.imm);
          chk("fmt", 64'(bus.o_fmt), 64'(e.fmt));
          chk("illegal", 64'(bus.o_illegal), 64'(e.ill));
          chk("tag", 64'(bus.o_tag), 64'(e.tag));
        end
      end
      hold   = bus.o_valid && !bus.i_ready;
      h_imm  = bus.o_imm;
      h_meta = {bus.o_fmt, bus.o_illegal, bus.o_tag};
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after accept.
  task automatic send(logic [31:0] ins, logic [7:0] tag,
                      logic [63:0] imm, logic [2:0] fmt);
    exp_t e;
    bus.i_valid = 1'b1;
    bus.i_instr = ins;
    bus.i_tag   = tag;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        e.imm = imm;
        e.fmt = fmt;
        e.ill = (fmt == 3'd0);
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL accept_timeout got=stuck exp=accept tag=%h", tag);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    total++;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.o_valid) return;
    end
    bad++;
    $display("FAIL drain_timeout got=%0d exp=0", q.size());
  endtask

  function automatic void ref_dec(input logic [31:0] ins,
                                  output logic [63:0] imm,
                                  output logic [2:0] fmt);
    logic [2:0] f3;
    f3  = ins[14:12];
    imm = 64'd0;
    fmt = 3'd0;
    case (ins[6:0])
      7'h13, 7'h1B, 7'h03, 7'h67: begin
        if ((ins[6:0] == 7'h13 || ins[6:0] == 7'h1B)
            && (f3 == 3'b001 || f3 == 3'b101)) begin
          fmt = 3'd6;
          if (ins[6:0] == 7'h13) imm = {58'd0, ins[25:20]};
          else imm = {59'd0, ins[24:20]};
        end else begin
          fmt = 3'd1;
          imm = {{52{ins[31]}}, ins[31:20]};
        end
      end
      7'h23: begin
        fmt = 3'd2;
        imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'h63: begin
        fmt = 3'd3;
        imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25],
               ins[11:8], 1'b0};
      end
      7'h37, 7'h17: begin
        fmt = 3'd4;
        imm = {{32{ins[31]}}, ins[31:12], 12'd0};
      end
      7'h6F: begin
        fmt = 3'd5;
        imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20],
               ins[30:21], 1'b0};
      end
      default: ;
    endcase
  endfunction

  localparam int ND = 14;
  logic [31:0] d_ins [ND] = '{
    32'hFFF00093, 32'h43F0D093, 32'hFE000EE3, 32'hFE000FE3,
    32'h800000B7, 32'h0000007F, 32'hFE20AC23, 32'h001000EF,
    32'h03F0909B, 32'h7FF0809B, 32'h12345097, 32'h80002083,
    32'h00B50533, 32'hFFC08067};
  logic [63:0] d_imm [ND] = '{
    64'hFFFFFFFFFFFFFFFF, 64'h000000000000003F,
    64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFE,
    64'hFFFFFFFF80000000, 64'h0000000000000000,
    64'hFFFFFFFFFFFFFFF8, 64'h0000000000000800,
    64'h000000000000001F, 64'h00000000000007FF,
    64'h0000000012345000, 64'hFFFFFFFFFFFFF800,
    64'h0000000000000000, 64'hFFFFFFFFFFFFFFFC};
  logic [2:0] d_fmt [ND] = '{
    3'd1, 3'd6, 3'd3, 3'd3, 3'd4, 3'd0, 3'd2,
    3'd5, 3'd6, 3'd1, 3'd4, 3'd1, 3'd0, 3'd1};
  logic [6:0] ops [9] = '{
    7'h03, 7'h67, 7'h13, 7'h1B, 7'h23,
    7'h63, 7'h37, 7'h17, 7'h6F};

  bit bp_done = 0;
  bit st_done = 0;

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_instr = 32'hFFF00093;
    bus.i_tag   = 8'h5A;
    bus.i_ready = 1'b1;
    #3;
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_ready", 64'(bus.o_ready), 64'd1);
    chk("rst_imm", bus.o_imm, 64'd0);
    chk("rst_fmt", 64'(bus.o_fmt), 64'd0);
    chk("rst_ill", 64'(bus.o_illegal), 64'd0);
    chk("rst_tag", 64'(bus.o_tag), 64'd0);
    bus.i_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ignore_valid", 64'(bus.o_valid), 64'd0);
    rst = 1'b0;
    bus.i_valid = 1'b0;

    // Directed table, streamed back to back.
    @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++)
      send(d_ins[i], 8'(8'h40 + i), d_imm[i], d_fmt[i]);
    bus.i_valid = 1'b0;
    drain();

    // Backpressure: tag 1 on outputs, 2 in skid, 3 held.
    rdy_fix = 0;
    @(posedge clk);
    #1;
    fork
      begin
        send(32'hFFF00093, 8'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
        send(32'h43F0D093, 8'd2, 64'h3F, 3'd6);
        send(32'h800000B7, 8'd3, 64'hFFFFFFFF80000000, 3'd4);
        bus.i_valid = 1'b0;
        bp_done = 1;
      end
    join_none
    repeat (4) @(negedge clk);
    chk("bp_tag_held", 64'(bus.o_tag), 64'd1);
    chk("bp_valid", 64'(bus.o_valid), 64'd1);
    chk("bp_ready_low", 64'(bus.o_ready), 64'd0);
    chk("bp_in_tag", 64'(bus.i_tag), 64'd3);
    rdy_fix = 1;
    for (int n = 0; n < 50 && !bp_done; n++) @(negedge clk);
    chk("bp_done", 64'(bp_done), 64'd1);
    drain();

    // Random legal stream with random downstream ready.
    @(posedge clk);
    #1;
    rdy_rand = 1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [31:0] r;
          logic [31:0] ins;
          logic [63:0] imm;
          logic [2:0]  fmt;
          r   = $urandom();
          ins = {r[31:7], ops[$urandom_range(0, 8)]};
          ref_dec(ins, imm, fmt);
          send(ins, 8'(i), imm, fmt);
          if ($urandom_range(0, 3) == 0) begin
            bus.i_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        bus.i_valid = 1'b0;
        st_done = 1;
      end
    join_none
    for (int n = 0; n < 3000 && !st_done; n++) @(negedge clk);
    chk("stream_done", 64'(st_done), 64'd1);
    rdy_rand = 0;
    rdy_fix  = 1;
    drain();

    // Async reset while in SKID.
    rdy_fix = 0;
    @(posedge clk);
    #1;
    send(32'hFE20AC23, 8'h10, 64'hFFFFFFFFFFFFFFF8, 3'd2);
    send(32'h001000EF, 8'h11, 64'h800, 3'd5);
    bus.i_valid = 1'b0;
    chk("skid_ready_low", 64'(bus.o_ready), 64'd0);
    chk("skid_tag", 64'(bus.o_tag), 64'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.o_valid), 64'd0);
    chk("arst_ready", 64'(bus.o_ready), 64'd1);
    chk("arst_tag", 64'(bus.o_tag), 64'd0);
    chk("arst_imm", bus.o_imm, 64'd0);
    q.delete();
    rdy_fix = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'hFFC08067, 8'h77, 64'hFFFFFFFFFFFFFFFC, 3'd1);
    bus.i_valid = 1'b0;
    chk("post_rst_valid", 64'(bus.o_valid), 64'd1);
    chk("post_rst_tag", 64'(bus.o_tag), 64'h77);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
